mux_scan_ctrl: RTL
==================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter MUX_LAT, default 1, SHALL give the mux select-to-output latency in clk cycles; legal range 0..3.
REQ-002 clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL be a scan request, sampled only in IDLE.
REQ-005 abort  input  1  SHALL cancel an in-progress scan.
REQ-006 first_sel  input  8  SHALL be the first mux index to scan, latched on start.
REQ-007 last_sel  input  8  SHALL be the last mux index to scan (inclusive), latched on start.
REQ-008 mux_out  input  1  SHALL be the 1-bit output of the 256:1 mux.
REQ-009 sel  output  8  SHALL drive the 256:1 mux select.
REQ-010 busy  output  1  SHALL be high in SCAN and DRAIN.
REQ-011 done  output  1  SHALL be a one-cycle pulse on normal scan completion.
REQ-012 ones_cnt  output  9  SHALL be the number of sampled ones, 0..256.
REQ-013 first_hit  output  8  SHALL be the first index, in scan order, that sampled 1.
REQ-014 hit_valid  output  1  SHALL be high when first_hit is meaningful.

Function
REQ-015 The FSM SHALL have states IDLE, SCAN, DRAIN and DONE.
- IDLE->SCAN on start.
- SCAN->DRAIN after last_sel is issued.
- DRAIN->DONE when the sample pipeline is empty.
- DONE->IDLE unconditionally.
REQ-016 On accepting start at edge T0, sel SHALL equal first_sel from T0 and increment by 1 (mod 256) each cycle until it equals the latched last_sel.
REQ-017 The scan length SHALL be N = ((last_sel - first_sel) mod 256) + 1, so last_sel < first_sel wraps through 255->0, and first_sel == last_sel scans exactly one index.
REQ-018 Each issued index SHALL enter a MUX_LAT-deep valid/index delay line; mux_out SHALL be sampled only when the delayed valid is high, and attributed to the delayed index.
- With MUX_LAT = 0, mux_out SHALL be sampled in the same cycle sel is driven.
REQ-019 done SHALL be high for exactly the single cycle starting N + MUX_LAT cycles after T0; busy SHALL fall in that same cycle.
REQ-020 ones_cnt, first_hit and hit_valid SHALL clear on start acceptance and then hold their final values from done until the next accepted start.
REQ-021 first_hit SHALL update only on the first sampled 1; hit_valid = 0 SHALL imply first_hit = 0.
REQ-022 start while busy, or in DONE, SHALL be ignored.
REQ-023 abort in SCAN or DRAIN SHALL force IDLE on the next edge, flush the delay line, and suppress done; results SHALL hold partial values.
REQ-024 abort and start asserted together in IDLE SHALL give abort priority, so start is not accepted.
REQ-025 sel SHALL hold its last value in IDLE.

Reset
REQ-026 On rst_n low, all outputs and state SHALL clear immediately, independent of clk: state = IDLE, sel = 0, busy = 0, done = 0, ones_cnt = 0, first_hit = 0, hit_valid = 0, delay line empty.
REQ-027 Reset asserted mid-scan SHALL discard the scan with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Configuration
REQ-028 With macro MUX_SCAN_CAPTURE_EN defined, the block SHALL add output cap_bits[255:0].
- On each sample, the bit at the sampled index is written.
- Unscanned bits SHALL read 0.
- cap_bits clears on start and on reset.
REQ-029 Without MUX_SCAN_CAPTURE_EN, the cap_bits port and its storage SHALL be absent; all other behaviour is unchanged.

Verification
REQ-030 Mux input pattern 0xA3 (bits 0,1,5,7 set), MUX_LAT = 1, scan 0..255 -> done at T0+257, ones_cnt = 4, first_hit = 0, hit_valid = 1.
REQ-031 Same pattern, first_sel = 2, last_sel = 6 -> sel steps 2,3,4,5,6; done at T0+6; ones_cnt = 1; first_hit = 5.
REQ-032 Wrap scan with first_sel = 250, last_sel = 1 on the same pattern -> N = 8, ones_cnt = 2, first_hit = 0, sel sequence 250..255,0,1.
REQ-033 All-zero input, first_sel = last_sel = 9 -> N = 1, ones_cnt = 0, hit_valid = 0, done at T0+2.
REQ-034 abort at T0+3 during a full scan -> busy low at T0+4, no done pulse; a following start completes normally; a second start pulsed while busy has no effect.
REQ-035 rst_n pulsed low mid-clock-cycle during SCAN -> all outputs 0 before the next clk edge; with MUX_SCAN_CAPTURE_EN defined, cap_bits = 0 and after a 0..7 scan of 0xA3, cap_bits[7:0] = 0xA3.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
//
// Walks the select of an external 256:1 mux across an inclusive index range
// (wrapping through 255 -> 0). Each issued index travels down a MUX_LAT-deep
// valid/index delay line so that mux_out is sampled only when the matching
// select has had time to propagate. Each sample is attributed to its delayed
// index. The block counts the ones seen and records the first index that
// read 1.
//
// Optional feature: define MUX_SCAN_CAPTURE_EN to add cap_bits[255:0]. This
// is a per-index capture of every sampled bit. It is cleared on start and on
// reset, and indices that were not scanned read 0.
//
// Parameters
//   MUX_LAT    select-to-output latency of the mux in clk cycles (0..3)
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      scan request, honoured only in IDLE and only without abort
//   abort      cancels a scan in SCAN/DRAIN; results keep partial values
//   first_sel  first index to scan, latched on start
//   last_sel   last index to scan (inclusive), latched on start
//   mux_out    1-bit output of the external mux
//   sel        mux select; holds its last value in IDLE
//   busy       high in SCAN and DRAIN
//   done       one-cycle pulse on normal completion
//   ones_cnt   number of sampled ones (0..256)
//   first_hit  first index, in scan order, that sampled 1 (0 if none)
//   cap_bits   captured bits per index (MUX_SCAN_CAPTURE_EN only)
//   hit_valid  first_hit is meaningful
// -----------------------------------------------------------------------------
module mux_scan_ctrl #(
  parameter int unsigned MUX_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [7:0]   first_sel,
  input  logic [7:0]   last_sel,
  input  logic         mux_out,
  output logic [7:0]   sel,
  output logic         busy,
  output logic         done,
  output logic [8:0]   ones_cnt,
  output logic [7:0]   first_hit,
`ifdef MUX_SCAN_CAPTURE_EN
  output logic [255:0] cap_bits,
`endif
  output logic         hit_valid
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t     state_r;
  state_t     state_nx_s;
  logic [7:0] last_r;
  logic       accept_s;
  logic       flush_s;
  logic       issue_s;
  logic       at_last_s;
  logic       samp_v_s;
  logic [7:0] samp_idx_s;
  logic       take_s;
  logic       drain_empty_s;

  assign issue_s   = (state_r == ST_SCAN);
  assign at_last_s = (sel == last_r);
  // A sample landing on the abort edge belongs to the cancelled scan.
  assign take_s    = samp_v_s & ~flush_s;

  generate
    if (MUX_LAT == 32'd0) begin : g_no_delay
      // The mux is combinational: sample in the same cycle sel is driven.
      assign samp_v_s      = issue_s;
      assign samp_idx_s    = sel;
      assign drain_empty_s = 1'b1;
    end else begin : g_delay
      logic [MUX_LAT-1:0]      pipe_v_r;
      logic [MUX_LAT-1:0][7:0] pipe_idx_r;
      // Stage 0 of each line is the index being issued this cycle.
      // The top stage is the entry being sampled.
      logic [MUX_LAT:0]        line_v_s;
      logic [MUX_LAT:0][7:0]   line_idx_s;

      assign line_v_s   = {pipe_v_r, issue_s};
      assign line_idx_s = {pipe_idx_r, sel};
      assign samp_v_s   = line_v_s[MUX_LAT];
      assign samp_idx_s = line_idx_s[MUX_LAT];
      // The line is empty after this edge when nothing sits below the
      // entry that is being sampled now.
      assign drain_empty_s = ~|line_v_s[MUX_LAT-1:0];

      // Valid/index delay line; an abort empties it
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_v_r   <= '0;
          pipe_idx_r <= '0;
        end else if (flush_s) begin
          pipe_v_r   <= '0;
        end else begin
          pipe_v_r   <= line_v_s[MUX_LAT-1:0];
          pipe_idx_r <= line_idx_s[MUX_LAT-1:0];
        end
      end
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic, start acceptance and abort flush decode
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    flush_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !abort) begin
          accept_s   = 1'b1;
          state_nx_s = ST_SCAN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (abort) begin
          flush_s    = 1'b1;
          state_nx_s = ST_IDLE;
        end else if (at_last_s) begin
          // Without a delay line nothing is left to drain after the last issue.
          if (MUX_LAT == 32'd0) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_DRAIN;
          end
        end else begin
          state_nx_s = ST_SCAN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          flush_s    = 1'b1;
          state_nx_s = ST_IDLE;
        end else if (drain_empty_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Registered status flags, decoded from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nx_s == ST_SCAN) || (state_nx_s == ST_DRAIN);
      done <= (state_nx_s == ST_DONE);
    end
  end

  // Select generator: loads first_sel on start, steps until the latched last index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel    <= 8'd0;
      last_r <= 8'd0;
    end else if (accept_s) begin
      sel    <= first_sel;
      last_r <= last_sel;
    end else if (issue_s && !abort && !at_last_s) begin
      sel    <= sel + 8'd1;
    end
  end

  // Scan results: cleared on start, updated per accepted sample, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_cnt  <= 9'd0;
      first_hit <= 8'd0;
      hit_valid <= 1'b0;
    end else if (accept_s) begin
      ones_cnt  <= 9'd0;
      first_hit <= 8'd0;
      hit_valid <= 1'b0;
    end else if (take_s && mux_out) begin
      ones_cnt <= ones_cnt + 9'd1;
      if (!hit_valid) begin
        first_hit <= samp_idx_s;
        hit_valid <= 1'b1;
      end
    end
  end

`ifdef MUX_SCAN_CAPTURE_EN
  // Per-index capture of every accepted sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_bits <= 256'd0;
    end else if (accept_s) begin
      cap_bits <= 256'd0;
    end else if (take_s) begin
      cap_bits[samp_idx_s] <= mux_out;
    end
  end
`endif

endmodule
